mso_interpolator: RTL and testbench

//   Polyphase FIR interpolator (upsample by FACTOR) for the MSO sample path.
//   It is the reconstruction counterpart of the fir decimation stage.

---
 rtl/mso_interpolator.sv | 178 +++++++++++++++++
 tb/tb_mso_interpolator.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mso_interpolator.sv
// Polyphase FIR interpolator: one input sample yields FACTOR filtered outputs via a single shared MAC.
// Latency: input accepted at edge E0 -> first out_valid after E0+K; K+1 cycles per output minimum.
// Backpressure: in_ready low while busy; an output is held stable in OUT until out_ready, stalling the MAC.
module mso_interpolator #(
  parameter int DATA_WIDTH  = 12,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 8,
  parameter int FACTOR      = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [COEFF_WIDTH*NUM_TAPS-1:0]     coeff,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DATA_WIDTH-1:0]        in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [DATA_WIDTH-1:0]        out_data,
  output logic                                out_sat,
  output logic                                busy
);

  // Taps per polyphase branch and the counter / datapath widths derived from it.
  localparam int K      = NUM_TAPS / FACTOR;
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int PW     = $clog2(FACTOR);
  localparam int IW     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_W  = DATA_WIDTH + COEFF_WIDTH + $clog2(K) + 1;
  localparam int SHIFT  = COEFF_WIDTH - 1;

  // Output clamp limits expressed at accumulator width so the compare stays signed.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                         state;
  logic [PW-1:0]                  phase;
  logic [KW-1:0]                  k;
  logic signed [ACC_W-1:0]        acc;
  logic signed [DATA_WIDTH-1:0]   x [K];

  logic signed [COEFF_WIDTH-1:0]  h [NUM_TAPS];
  logic [IW-1:0]                  tap_idx;
  logic signed [COEFF_WIDTH-1:0]  h_sel;
  logic signed [DATA_WIDTH-1:0]   x_sel;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        acc_sum;
  logic signed [ACC_W-1:0]        r;
  logic                           sat_hi;
  logic                           sat_lo;
  logic [DATA_WIDTH-1:0]          sat_dat;

  // Unpack the flat coefficient bus into a signed tap array.
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      h[i] = coeff[i*COEFF_WIDTH +: COEFF_WIDTH];
    end
  end

  // Select h[phase + k*FACTOR] and x[k] for this MAC cycle; coeff is sampled live every cycle.
  always_comb begin
    tap_idx = IW'(phase) + IW'(k) * IW'(FACTOR);
    h_sel   = h[tap_idx];
    x_sel   = x[k];
  end

  // Full-precision signed product and accumulate; ACC_W leaves headroom so nothing wraps.
  always_comb begin
    prod    = PROD_W'(x_sel) * PROD_W'(h_sel);
    acc_sum = acc + ACC_W'(prod);
  end

  // Rescale from Q1.(COEFF_WIDTH-1) by arithmetic shift (floor), then clamp to the sample range.
  always_comb begin
    r      = acc_sum >>> SHIFT;
    sat_hi = (r > SAT_MAX);
    sat_lo = (r < SAT_MIN);
    if (sat_hi) begin
      sat_dat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (sat_lo) begin
      sat_dat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_dat = r[DATA_WIDTH-1:0];
    end
  end

  // Control FSM with delay line, MAC accumulator and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase     <= '0;
      k         <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < K; i++) begin
        x[i] <= '0;
      end
    end else if (clear) begin
      // Flush wins over any handshake this cycle; a held output is discarded.
      state     <= ST_IDLE;
      phase     <= '0;
      k         <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < K; i++) begin
        x[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            x[0] <= in_data;
            for (int i = 1; i < K; i++) begin
              x[i] <= x[i-1];
            end
            phase    <= '0;
            k        <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_MAC;
          end else begin
            in_ready <= 1'b1;
          end
        end

        ST_MAC: begin
          acc <= acc_sum;
          if (k == KW'(K - 1)) begin
            // Last tap of this phase: result is registered on the same edge.
            out_data  <= sat_dat;
            out_sat   <= sat_hi | sat_lo;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            k <= k + KW'(1);
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (phase == PW'(FACTOR - 1)) begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              phase <= phase + PW'(1);
              k     <= '0;
              acc   <= '0;
              state <= ST_MAC;
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mso_interpolator.sv
// Scoreboard bench for mso_interpolator: stimulus pushes expected outputs, a monitor pops on transfer.
// Directed impulse, saturation, stall, clear and async-reset cases, then a seeded random run.
// Every wait is bounded; a watchdog ends the run if the design never completes.
`timescale 1ns/1ps
module tb_mso_interpolator;

  localparam int DW = 12;
  localparam int CW = 8;
  localparam int NT = 8;
  localparam int L  = 4;
  localparam int K  = NT / L;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CW*NT-1:0]  coeff = '0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic              out_sat;
  logic              busy;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   xfer_cnt = 0;
  int   hc [NT];
  int   xm [K];
  bit   rnd_mode = 1'b0;

  mso_interpolator #(
    .DATA_WIDTH (DW),
    .COEFF_WIDTH(CW),
    .NUM_TAPS   (NT),
    .FACTOR     (L)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .coeff    (coeff),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push_exp(input int val, input bit sat);
    exp_t e;
    e.d = DW'(val);
    e.s = sat;
    exp_q.push_back(e);
  endfunction

  function automatic void push4(input int val, input bit sat);
    for (int i = 0; i < L; i++) push_exp(val, sat);
  endfunction

  // Reference: y[p] = sum_k h[p+k*L]*x[n-k], floor-shift by CW-1, clamp to DW bits.
  function automatic void model_push(input int xin);
    longint acc;
    longint r;
    for (int i = K - 1; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = xin;
    for (int p = 0; p < L; p++) begin
      acc = 0;
      for (int kk = 0; kk < K; kk++) acc += longint'(hc[p + kk*L]) * longint'(xm[kk]);
      r = acc >>> (CW - 1);
      if (r > 2047)       push_exp(2047, 1'b1);
      else if (r < -2048) push_exp(-2048, 1'b1);
      else                push_exp(int'(r), 1'b0);
    end
  endfunction

  task automatic apply_coeffs();
    for (int i = 0; i < NT; i++) coeff[i*CW +: CW] = CW'(hc[i]);
  endtask

  task automatic set_impulse();
    for (int i = 0; i < NT; i++) hc[i] = (i < L) ? 64 : 32;
    apply_coeffs();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || busy) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Offer one sample; optionally verify out_valid appears exactly K edges after acceptance.
  task automatic send(input int xin, input bit chk_lat);
    wait_ready();
    in_valid = 1'b1;
    in_data  = DW'(xin);
    tick();
    in_valid = 1'b0;
    if (chk_lat) begin
      check("accept_busy", busy, 1);
      check("accept_in_ready", in_ready, 0);
      check("lat_e0_valid", out_valid, 0);
      tick();
      check("lat_e1_valid", out_valid, 0);
      tick();
      check("lat_e2_valid", out_valid, 1);
    end
  endtask

  task automatic impulse_run();
    push4(50, 1'b0);
    send(100, 1'b1);
    push4(25, 1'b0);
    send(0, 1'b1);
    push4(0, 1'b0);
    send(0, 1'b1);
    wait_drain();
  endtask

  // Monitor: a transfer happens on the next rising edge when both handshake signals are high.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !clear && out_valid && out_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", out_data, -1);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.d);
        check("out_sat", out_sat, e.s);
      end
    end
  end

  // Random downstream readiness for the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    int xr;
    for (int i = 0; i < K; i++) xm[i] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // 1: impulse response with latency checks
    out_ready = 1'b1;
    set_impulse();
    impulse_run();

    // 2: saturation, positive then negative
    clear_pulse();
    for (int i = 0; i < NT; i++) hc[i] = 127;
    apply_coeffs();
    push4(2031, 1'b0);
    send(2047, 1'b0);
    push4(2047, 1'b1);
    send(2047, 1'b0);
    wait_drain();
    clear_pulse();
    push4(-2032, 1'b0);
    send(-2048, 1'b0);
    push4(-2048, 1'b1);
    send(-2048, 1'b0);
    wait_drain();

    // 3: output stall with ignored input pulses
    clear_pulse();
    set_impulse();
    out_ready = 1'b0;
    push4(50, 1'b0);
    send(100, 1'b0);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 12'd999;
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 50);
      check("stall_sat", out_sat, 0);
      check("stall_in_ready", in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    push4(25, 1'b0);
    send(0, 1'b0);
    wait_drain();

    // 4: clear during MAC of phase 2 drops the rest and zeroes history
    base = xfer_cnt;
    push_exp(50, 1'b0);
    push_exp(50, 1'b0);
    send(100, 1'b0);
    n = 0;
    while (xfer_cnt < base + 2 && n < 200) begin
      tick();
      n++;
    end
    check("clr_reached_phase2", xfer_cnt - base, 2);
    check("clr_busy_before", busy, 1);
    clear_pulse();
    check("clr_busy", busy, 0);
    check("clr_out_valid", out_valid, 0);
    check("clr_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("clr_no_valid", out_valid, 0);
      tick();
    end
    check("clr_queue", exp_q.size(), 0);
    push4(50, 1'b0);
    send(100, 1'b0);
    wait_drain();

    // 5: async reset while an output is held
    out_ready = 1'b0;
    send(100, 1'b0);
    wait_out_valid();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_data", out_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    impulse_run();

    // 6: random samples and coefficients against the reference model
    clear_pulse();
    for (int i = 0; i < K; i++) xm[i] = 0;
    rnd_mode = 1'b1;
    for (int s = 0; s < 200; s++) begin
      repeat ($urandom_range(0, 2)) tick();
      wait_ready();
      for (int i = 0; i < NT; i++) hc[i] = int'($urandom_range(0, 255)) - 128;
      apply_coeffs();
      xr = int'($urandom_range(0, 4095)) - 2048;
      model_push(xr);
      send(xr, 1'b0);
    end
    wait_drain();
    rnd_mode  = 1'b0;
    out_ready = 1'b1;

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
